// File: rtl/fp_multiplier.sv
// ---------------------------------------------------------------------------
// fp_multiplier
//   IEEE-754 binary64 multiplier, round-to-nearest-ties-to-even. The whole
//   datapath is combinational and feeds a single output register, so a
//   product appears on `result` one rising edge after its operands are
//   sampled. A new operand pair may be applied on every cycle.
//
// Ports
//   clk     in   1   rising-edge clock
//   rst_n   in   1   asynchronous active-low reset, clears `result` to 0
//   A       in  64   operand A (binary64 encoding)
//   B       in  64   operand B (binary64 encoding)
//   result  out 64   registered product A*B (binary64 encoding)
// ---------------------------------------------------------------------------
module fp_multiplier (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] A,
    input  logic [63:0] B,
    output logic [63:0] result
);

    localparam logic [63:0] QNAN = 64'h7FF8_0000_0000_0000;

    // Leading-zero count of a 53-bit significand. Returns 53 for zero;
    // zero operands never reach the datapath result, so that value is unused.
    function automatic logic [5:0] lzc53(input logic [52:0] v);
        logic [5:0] n;
        logic       found;
        n     = 6'd0;
        found = 1'b0;
        for (int i = 52; i >= 0; i--) begin
            if (!found) begin
                if (v[i]) found = 1'b1;
                else      n     = n + 6'd1;
            end
        end
        return n;
    endfunction

    // -----------------------------------------------------------------------
    // Operand unpacking and pre-normalization (identical for A and B)
    // -----------------------------------------------------------------------
    logic [63:0]        ops     [2];
    logic [52:0]        sig_n   [2];   // significand with MSB = leading 1
    logic signed [12:0] exp_n   [2];   // biased exponent after normalization
    logic [1:0]         is_nan;
    logic [1:0]         is_inf;
    logic [1:0]         is_zero;

    assign ops[0] = A;
    assign ops[1] = B;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_unpack
            logic [10:0] e;
            logic [51:0] f;
            logic [10:0] e_eff;
            logic [52:0] s;
            logic [5:0]  lz;

            assign e = ops[gi][62:52];
            assign f = ops[gi][51:0];

            // Subnormals carry the same scale as exponent field 1, with no
            // hidden bit.
            assign e_eff = (e == 11'd0) ? 11'd1 : e;
            assign s     = {(e != 11'd0), f};
            assign lz    = lzc53(s);

            assign is_nan[gi]  = (e == 11'h7FF) && (f != 52'd0);
            assign is_inf[gi]  = (e == 11'h7FF) && (f == 52'd0);
            assign is_zero[gi] = (e == 11'd0)   && (f == 52'd0);

            // Shifting a subnormal up by its leading-zero count makes both
            // operands look normal; the exponent can then go below 1.
            assign sig_n[gi] = s << lz;
            assign exp_n[gi] = $signed({2'b00, e_eff}) - $signed({7'b0000000, lz});
        end
    endgenerate

    logic sign_p;
    assign sign_p = A[63] ^ B[63];

    // -----------------------------------------------------------------------
    // Significand product and normalization
    // -----------------------------------------------------------------------
    logic [105:0]       prod;
    logic               prod_hi;
    logic [105:0]       prod_n;
    logic signed [12:0] exp_p;

    // Both inputs have their MSB set, so the product lies in [2^104, 2^106).
    assign prod    = sig_n[0] * sig_n[1];
    assign prod_hi = prod[105];
    assign prod_n  = prod_hi ? prod : {prod[104:0], 1'b0};
    assign exp_p   = exp_n[0] + exp_n[1] - 13'sd1023 + $signed({12'd0, prod_hi});

    // -----------------------------------------------------------------------
    // Denormalizing shift for tiny results
    // -----------------------------------------------------------------------
    logic               tiny;
    logic signed [12:0] sh_full;
    logic [5:0]         sh;
    logic [169:0]       wide;
    logic [52:0]        mant;
    logic               guard;
    logic               sticky;

    assign tiny    = (exp_p <= 13'sd0);
    assign sh_full = 13'sd1 - exp_p;
    // Beyond 55 positions every product bit already sits below the guard,
    // so clamping the shift changes nothing but keeps the shifter small.
    assign sh      = !tiny                  ? 6'd0  :
                     (sh_full > 13'sd56)    ? 6'd56 : sh_full[5:0];

    // 64 extra zero bits below the product catch whatever the shift pushes
    // out, so sticky is simply the OR of everything under the guard bit.
    assign wide   = {prod_n, 64'd0} >> sh;
    assign mant   = wide[169:117];
    assign guard  = wide[116];
    assign sticky = |wide[115:0];

    // -----------------------------------------------------------------------
    // Rounding and packing
    // -----------------------------------------------------------------------
    logic               inc;
    logic [53:0]        mant_r;
    logic signed [12:0] exp_r;
    logic [51:0]        frac_r;
    logic               ovf;

    assign inc    = guard & (sticky | mant[0]);
    assign mant_r = {1'b0, mant} + {53'd0, inc};

    // Normal path: a carry out of rounding leaves 1.000..0, so shift right
    // and bump the exponent. Tiny path cannot carry past bit 52.
    assign exp_r  = mant_r[53] ? (exp_p + 13'sd1) : exp_p;
    assign frac_r = mant_r[53] ? mant_r[52:1] : mant_r[51:0];
    assign ovf    = !tiny && (exp_r >= 13'sd2047);

    logic [63:0] result_next;

    always_comb begin
        result_next = 64'd0;
        if ((|is_nan) || (is_inf[0] && is_zero[1]) || (is_zero[0] && is_inf[1])) begin
            result_next = QNAN;
        end else if (|is_inf) begin
            result_next = {sign_p, 11'h7FF, 52'd0};
        end else if (|is_zero) begin
            result_next = {sign_p, 63'd0};
        end else if (ovf) begin
            result_next = {sign_p, 11'h7FF, 52'd0};
        end else if (tiny) begin
            // Rounding into bit 52 promotes the subnormal to the smallest
            // normal; the exponent field is then exactly that bit.
            result_next = {sign_p, 10'd0, mant_r[52], mant_r[51:0]};
        end else begin
            result_next = {sign_p, exp_r[10:0], frac_r};
        end
    end

    // -----------------------------------------------------------------------
    // Output register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) result <= 64'd0;
        else        result <= result_next;
    end

endmodule

// File: tb/tb_fp_multiplier.sv
// ---------------------------------------------------------------------------
// tb_fp_multiplier
//   Self-checking bench for fp_multiplier. Directed cases use hand-derived
//   constants; random cases are checked against the simulator's own
//   double-precision multiply with NaNs canonicalized.
// ---------------------------------------------------------------------------
module tb_fp_multiplier;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] A;
    logic [63:0] B;
    logic [63:0] result;

    int          tests = 0;
    int          fails = 0;
    logic [63:0] prev_want = 64'd0;
    bit          have_prev = 1'b0;

    fp_multiplier dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .A      (A),
        .B      (B),
        .result (result)
    );

    always #5 clk = ~clk;

    // Reference: host IEEE double multiply (round-to-nearest-even), with any
    // NaN outcome replaced by the canonical quiet NaN.
    function automatic logic [63:0] model(input logic [63:0] a, input logic [63:0] b);
        logic [63:0] p;
        p = $realtobits($bitstoreal(a) * $bitstoreal(b));
        if (p[62:52] == 11'h7FF && p[51:0] != 52'd0) p = 64'h7FF8_0000_0000_0000;
        return p;
    endfunction

    // Random operand biased toward interesting exponent regions.
    function automatic logic [63:0] rand_op();
        logic [63:0] r;
        logic [51:0] f;
        logic [10:0] e;
        int          cls;
        r   = {$urandom, $urandom};
        f   = r[51:0];
        cls = $urandom_range(0, 11);
        case (cls)
            0:  e = 11'd0;                                      // subnormal
            1:  e = 11'h7FF;                                    // inf / NaN
            2:  e = 11'(1023 - 30 + $urandom_range(0, 60));     // near 1.0
            3:  e = 11'(480 + $urandom_range(0, 100));          // underflow region in pairs
            4:  e = 11'(1500 + $urandom_range(0, 100));         // overflow region in pairs
            5:  e = 11'($urandom_range(1, 3));                  // tiny normals
            default: e = 11'($urandom_range(1, 2046));
        endcase
        if ($urandom_range(0, 9) == 0) f = 52'd0;
        if ($urandom_range(0, 9) == 0) f = {52{1'b1}};
        return {r[63], e, f};
    endfunction

    task automatic check(input string tag, input logic [63:0] want);
        tests++;
        assert (result === want) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, result, want);
        end
    endtask

    // Drive operands on the falling edge, check one rising edge later.
    // Before changing inputs, confirm the previous product held steady.
    task automatic apply(input string tag, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] want);
        @(negedge clk);
        if (have_prev) check({tag, "_hold"}, prev_want);
        A = a;
        B = b;
        @(posedge clk);
        #1;
        check(tag, want);
        $display("[TB] %s: %h x %h -> %h", tag, a, b, result);
        prev_want = want;
        have_prev = 1'b1;
    endtask

    initial begin
        logic [63:0] ra;
        logic [63:0] rb;

        // ---------------- reset ----------------
        rst_n = 1'b1;
        A     = 64'h4008_0000_0000_0000;
        B     = 64'h4004_0000_0000_0000;
        #1 rst_n = 1'b0;
        #1 check("reset_async", 64'd0);
        @(posedge clk);
        #1 check("reset_hold", 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- directed ----------------
        apply("mul_3x2p5",      64'h4008_0000_0000_0000, 64'h4004_0000_0000_0000, 64'h401E_0000_0000_0000);
        apply("mul_half_sq",    64'h3FE0_0000_0000_0000, 64'h3FE0_0000_0000_0000, 64'h3FD0_0000_0000_0000);
        apply("mul_neg",        64'hC000_0000_0000_0000, 64'h4010_0000_0000_0000, 64'hC020_0000_0000_0000);
        apply("mul_one",        64'h3FF0_0000_0000_0000, 64'h3FF0_0000_0000_0000, 64'h3FF0_0000_0000_0000);
        apply("minnorm_x2",     64'h0010_0000_0000_0000, 64'h4000_0000_0000_0000, 64'h0020_0000_0000_0000);
        apply("minnorm_half",   64'h0010_0000_0000_0000, 64'h3FE0_0000_0000_0000, 64'h0008_0000_0000_0000);
        apply("neg_zero",       64'hBFF0_0000_0000_0000, 64'h0000_0000_0000_0000, 64'h8000_0000_0000_0000);
        apply("inf_x_zero",     64'h7FF0_0000_0000_0000, 64'h0000_0000_0000_0000, 64'h7FF8_0000_0000_0000);
        apply("zero_x_inf",     64'h8000_0000_0000_0000, 64'hFFF0_0000_0000_0000, 64'h7FF8_0000_0000_0000);
        apply("inf_x_neg1",     64'h7FF0_0000_0000_0000, 64'hBFF0_0000_0000_0000, 64'hFFF0_0000_0000_0000);
        apply("nan_in",         64'h7FF0_0000_0000_0001, 64'h4008_0000_0000_0000, 64'h7FF8_0000_0000_0000);
        apply("overflow",       64'h7FEF_FFFF_FFFF_FFFF, 64'h4000_0000_0000_0000, 64'h7FF0_0000_0000_0000);
        apply("round_inexact",  64'h3FF0_0000_0000_0001, 64'h3FF0_0000_0000_0001, 64'h3FF0_0000_0000_0002);
        apply("tie_to_zero",    64'h0000_0000_0000_0001, 64'h3FE0_0000_0000_0000, 64'h0000_0000_0000_0000);
        apply("round_to_minsub",64'h0000_0000_0000_0001, 64'h3FE0_0000_0000_0001, 64'h0000_0000_0000_0001);
        apply("round_to_minnorm",64'h000F_FFFF_FFFF_FFFF, 64'h3FF0_0000_0000_0001, 64'h0010_0000_0000_0000);
        apply("deep_underflow", 64'h0000_0000_0000_0001, 64'h0000_0000_0000_0001, 64'h0000_0000_0000_0000);

        // ---------------- random back-to-back ----------------
        for (int i = 0; i < 300; i++) begin
            ra = rand_op();
            rb = rand_op();
            apply($sformatf("rand%0d", i), ra, rb, model(ra, rb));
        end

        // ---------------- reset mid-stream ----------------
        @(negedge clk);
        check("pre_reset_hold", prev_want);
        A = 64'h4008_0000_0000_0000;
        B = 64'hC004_0000_0000_0000;
        #2 rst_n = 1'b0;
        #1 check("midstream_clear", 64'd0);
        @(posedge clk);
        #1 check("midstream_held", 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 check("post_reset", 64'hC01E_0000_0000_0000);
        prev_want = 64'hC01E_0000_0000_0000;

        for (int i = 0; i < 40; i++) begin
            ra = rand_op();
            rb = rand_op();
            apply($sformatf("post%0d", i), ra, rb, model(ra, rb));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
